// File: rtl/axi_user_arbiter.sv
// Two-requester arbiter in front of a single AXI bridge user port.
// m0 is a read-only instruction port and m1 a read/write data port. One transaction
// is in flight at a time. When both ports request together, the port that was not
// served last wins. The request is captured on the grant edge, so the bridge sees
// stable fields even if the requester changes or drops its inputs.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_m0_* / o_m0_ready        m0 request (addr/size/blks) and completion pulse
//   i_m1_* / o_m1_ready        m1 request (op/addr/size/blks/wdata) and completion pulse
//   o_rdata, o_resp            shared response, nonzero only with a ready pulse
//   o_axi_io_*                 request to the bridge, valid for the whole busy phase
//   i_axi_io_*                 bridge completion pulse, read data and response

package axi_user_arbiter_pkg;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned BLKS_W = 8;
    localparam int unsigned RESP_W = 2;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [BLKS_W-1:0] blks;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

module axi_user_arbiter
    import axi_user_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_m0_valid,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [SIZE_W-1:0] i_m0_size,
    input  logic [BLKS_W-1:0] i_m0_blks,
    output logic              o_m0_ready,
    input  logic              i_m1_valid,
    input  logic              i_m1_op,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [SIZE_W-1:0] i_m1_size,
    input  logic [BLKS_W-1:0] i_m1_blks,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic [RESP_W-1:0] o_resp,
    output logic              o_axi_io_valid,
    output logic              o_axi_io_op,
    output logic [ADDR_W-1:0] o_axi_io_addr,
    output logic [SIZE_W-1:0] o_axi_io_size,
    output logic [BLKS_W-1:0] o_axi_io_blks,
    output logic [DATA_W-1:0] o_axi_io_wdata,
    input  logic              i_axi_io_ready,
    input  logic [DATA_W-1:0] i_axi_io_rdata,
    input  logic [RESP_W-1:0] i_axi_io_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_M0 = 2'd1,
        ST_BUSY_M1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0: m0 served last, 1: m1 served last
    req_t   req_q, req_d;
    logic   grant_m1;

    // State, round-robin memory and captured request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b0;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
        end
    end

    // Next state: grant from IDLE, return to IDLE on bridge completion.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        // m1 wins when alone, or on a tie when m0 was served last.
        grant_m1     = i_m1_valid && (!i_m0_valid || !last_grant_q);
        unique case (state_q)
            ST_IDLE: begin
                if (grant_m1) begin
                    state_d = ST_BUSY_M1;
                    req_d   = '{op: i_m1_op, addr: i_m1_addr, size: i_m1_size,
                                blks: i_m1_blks, wdata: i_m1_wdata};
                end else if (i_m0_valid) begin
                    state_d = ST_BUSY_M0;
                    req_d   = '{op: 1'b0, addr: i_m0_addr, size: i_m0_size,
                                blks: i_m0_blks, wdata: '0};
                end
            end
            ST_BUSY_M0: begin
                if (i_axi_io_ready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            ST_BUSY_M1: begin
                if (i_axi_io_ready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: bridge fields from the capture registers; the response is passed
    // straight through during the completion cycle only.
    always_comb begin
        o_axi_io_valid = 1'b0;
        o_axi_io_op    = req_q.op;
        o_axi_io_addr  = req_q.addr;
        o_axi_io_size  = req_q.size;
        o_axi_io_blks  = req_q.blks;
        o_axi_io_wdata = req_q.wdata;
        o_m0_ready     = 1'b0;
        o_m1_ready     = 1'b0;
        o_rdata        = '0;
        o_resp         = '0;
        unique case (state_q)
            ST_BUSY_M0: begin
                o_axi_io_valid = 1'b1;
                o_m0_ready     = i_axi_io_ready;
            end
            ST_BUSY_M1: begin
                o_axi_io_valid = 1'b1;
                o_m1_ready     = i_axi_io_ready;
            end
            default: ;
        endcase
        if (o_m0_ready || o_m1_ready) begin
            o_rdata = i_axi_io_rdata;
            o_resp  = i_axi_io_resp;
        end
    end

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Self-checking bench for axi_user_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_axi_user_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_m0_valid;
    logic [63:0]   i_m0_addr;
    logic [1:0]    i_m0_size;
    logic [7:0]    i_m0_blks;
    logic          o_m0_ready;
    logic          i_m1_valid;
    logic          i_m1_op;
    logic [63:0]   i_m1_addr;
    logic [1:0]    i_m1_size;
    logic [7:0]    i_m1_blks;
    logic [511:0]  i_m1_wdata;
    logic          o_m1_ready;
    logic [511:0]  o_rdata;
    logic [1:0]    o_resp;
    logic          o_axi_io_valid;
    logic          o_axi_io_op;
    logic [63:0]   o_axi_io_addr;
    logic [1:0]    o_axi_io_size;
    logic [7:0]    o_axi_io_blks;
    logic [511:0]  o_axi_io_wdata;
    logic          i_axi_io_ready;
    logic [511:0]  i_axi_io_rdata;
    logic [1:0]    i_axi_io_resp;

    axi_user_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_valid(i_m0_valid), .i_m0_addr(i_m0_addr), .i_m0_size(i_m0_size),
        .i_m0_blks(i_m0_blks), .o_m0_ready(o_m0_ready),
        .i_m1_valid(i_m1_valid), .i_m1_op(i_m1_op), .i_m1_addr(i_m1_addr),
        .i_m1_size(i_m1_size), .i_m1_blks(i_m1_blks), .i_m1_wdata(i_m1_wdata),
        .o_m1_ready(o_m1_ready), .o_rdata(o_rdata), .o_resp(o_resp),
        .o_axi_io_valid(o_axi_io_valid), .o_axi_io_op(o_axi_io_op),
        .o_axi_io_addr(o_axi_io_addr), .o_axi_io_size(o_axi_io_size),
        .o_axi_io_blks(o_axi_io_blks), .o_axi_io_wdata(o_axi_io_wdata),
        .i_axi_io_ready(i_axi_io_ready), .i_axi_io_rdata(i_axi_io_rdata),
        .i_axi_io_resp(i_axi_io_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: who owns the bridge and what was captured.
    bit           m_busy, m_owner, m_last, done0, done1;
    logic         m_op;
    logic [63:0]  m_addr;
    logic [1:0]   m_size;
    logic [7:0]   m_blks;
    logic [511:0] m_wdata;
    int           q_ready[$];   // ports whose ready pulse the DUT produced
    int           vcount;
    int           n_done;

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 0; done0 = 0; done1 = 0;
        m_op = 0; m_addr = '0; m_size = '0; m_blks = '0; m_wdata = '0;
    endtask

    task automatic model_update();
        done0 = 0; done1 = 0;
        if (!rst_n) return;
        if (m_busy) begin
            if (i_axi_io_ready) begin
                m_busy = 0;
                m_last = m_owner;
                if (m_owner) done1 = 1; else done0 = 1;
                n_done++;
            end
        end else if (i_m0_valid || i_m1_valid) begin
            m_owner = (i_m0_valid && i_m1_valid) ? !m_last : i_m1_valid;
            m_busy  = 1;
            if (m_owner) begin
                m_op = i_m1_op; m_addr = i_m1_addr; m_size = i_m1_size;
                m_blks = i_m1_blks; m_wdata = i_m1_wdata;
            end else begin
                m_op = 0; m_addr = i_m0_addr; m_size = i_m0_size;
                m_blks = i_m0_blks; m_wdata = '0;
            end
        end
    endtask

    task automatic check_outputs();
        bit r0, r1;
        r0 = m_busy && !m_owner && i_axi_io_ready;
        r1 = m_busy && m_owner && i_axi_io_ready;
        check_eq("valid", 512'(o_axi_io_valid), 512'(m_busy));
        check_eq("m0_ready", 512'(o_m0_ready), 512'(r0));
        check_eq("m1_ready", 512'(o_m1_ready), 512'(r1));
        check_eq("rdata", o_rdata, (r0 || r1) ? i_axi_io_rdata : 512'd0);
        check_eq("resp", 512'(o_resp), (r0 || r1) ? 512'(i_axi_io_resp) : 512'd0);
        if (m_busy) begin
            check_eq("op", 512'(o_axi_io_op), 512'(m_op));
            check_eq("addr", 512'(o_axi_io_addr), 512'(m_addr));
            check_eq("size", 512'(o_axi_io_size), 512'(m_size));
            check_eq("blks", 512'(o_axi_io_blks), 512'(m_blks));
            check_eq("wdata", o_axi_io_wdata, m_wdata);
        end
        if (o_axi_io_valid) vcount++;
        if (o_m0_ready) q_ready.push_back(0);
        if (o_m1_ready) q_ready.push_back(1);
    endtask

    // One clock: check settled outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        i_m0_valid = 0; i_m0_addr = '0; i_m0_size = '0; i_m0_blks = '0;
        i_m1_valid = 0; i_m1_op = 0; i_m1_addr = '0; i_m1_size = '0; i_m1_blks = '0;
        i_m1_wdata = '0; i_axi_io_ready = 0; i_axi_io_rdata = '0; i_axi_io_resp = '0;
    endtask

    // Assert reset mid-cycle; its effect must be visible without a clock edge.
    task automatic assert_reset(input string tag);
        rst_n = 0;
        #1;
        check_eq({tag, "_valid"}, 512'(o_axi_io_valid), 512'd0);
        check_eq({tag, "_m0_ready"}, 512'(o_m0_ready), 512'd0);
        check_eq({tag, "_m1_ready"}, 512'(o_m1_ready), 512'd0);
        check_eq({tag, "_addr"}, 512'(o_axi_io_addr), 512'd0);
        check_eq({tag, "_wdata"}, o_axi_io_wdata, 512'd0);
        check_eq({tag, "_op"}, 512'(o_axi_io_op), 512'd0);
        model_reset();
    endtask

    task automatic do_reset();
        assert_reset("rst");
        idle_inputs();
        tick();
        rst_n = 1;
        q_ready.delete();
        vcount = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit pend0, pend1;
        logic [63:0] a_m0, a_m1;
        n_done = 0;
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        assert_reset("por");
        rst_n = 1;

        // Single m0 read, bridge completes on the 5th busy cycle.
        q_ready.delete(); vcount = 0;
        i_m0_valid = 1; i_m0_addr = 64'h8000_0000; i_m0_size = 2'd3; i_m0_blks = 8'd0;
        tick();
        repeat (4) tick();
        i_axi_io_ready = 1; i_axi_io_rdata = 512'hDEAD; i_axi_io_resp = 2'd0;
        #1;
        check_eq("d040_m0_ready", 512'(o_m0_ready), 512'd1);
        check_eq("d040_rdata", o_rdata, 512'hDEAD);
        check_eq("d040_op", 512'(o_axi_io_op), 512'd0);
        tick();
        idle_inputs();
        tick();
        check_eq("d040_vcycles", 512'(vcount), 512'd5);
        check_eq("d040_npulse", 512'(q_ready.size()), 512'd1);

        // Tie right after reset goes to m1, then m0 after one idle cycle.
        do_reset();
        a_m0 = {$urandom, $urandom}; a_m1 = {$urandom, $urandom};
        i_m0_valid = 1; i_m0_addr = a_m0; i_m1_valid = 1; i_m1_addr = a_m1; i_m1_op = 0;
        tick();
        check_eq("d041_first_addr", 512'(o_axi_io_addr), 512'(a_m1));
        i_axi_io_ready = 1;
        tick();
        i_m1_valid = 0; i_axi_io_ready = 0;
        tick();
        check_eq("d041_gap_valid", 512'(o_axi_io_valid), 512'd1);
        check_eq("d041_second_addr", 512'(o_axi_io_addr), 512'(a_m0));
        i_axi_io_ready = 1;
        tick();
        idle_inputs();
        tick();
        check_eq("d041_npulse", 512'(q_ready.size()), 512'd2);
        if (q_ready.size() == 2) begin
            check_eq("d041_order0", 512'(q_ready[0]), 512'd1);
            check_eq("d041_order1", 512'(q_ready[1]), 512'd0);
        end

        // Both held valid: grants alternate m1, m0, m1, m0.
        do_reset();
        i_m0_valid = 1; i_m1_valid = 1; i_m0_addr = 64'h100; i_m1_addr = 64'h200;
        for (int c = 0; c < 40 && q_ready.size() < 4; c++) begin
            i_axi_io_ready = m_busy;
            tick();
        end
        check_eq("d042_npulse", 512'(q_ready.size()), 512'd4);
        for (int i = 0; i < q_ready.size() && i < 4; i++)
            check_eq($sformatf("d042_order%0d", i), 512'(q_ready[i]), 512'((i % 2 == 0) ? 1 : 0));
        idle_inputs();
        tick();

        // m1 write whose inputs change after the grant.
        do_reset();
        a_m1 = 64'h1234_5678_9ABC_DEF0;
        i_m1_valid = 1; i_m1_op = 1; i_m1_addr = a_m1; i_m1_size = 2'd2; i_m1_blks = 8'd7;
        i_m1_wdata = {64{8'hA5}};
        tick();
        i_m1_addr = ~a_m1; i_m1_wdata = '0; i_m1_op = 0;
        for (int c = 0; c < 3; c++) begin
            check_eq("d043_addr", 512'(o_axi_io_addr), 512'(a_m1));
            check_eq("d043_wdata", o_axi_io_wdata, {64{8'hA5}});
            check_eq("d043_op", 512'(o_axi_io_op), 512'd1);
            tick();
        end
        i_axi_io_ready = 1;
        tick();
        idle_inputs();
        tick();
        check_eq("d043_npulse", 512'(q_ready.size()), 512'd1);

        // Reset during an m1 transaction, then a normal m0 transaction.
        do_reset();
        i_m1_valid = 1; i_m1_op = 1; i_m1_addr = 64'hF00; i_m1_wdata = rand512();
        tick();
        tick();
        i_axi_io_ready = 1;
        assert_reset("d044");
        idle_inputs();
        tick();
        rst_n = 1;
        i_m0_valid = 1; i_m0_addr = 64'hABC;
        tick();
        i_axi_io_ready = 1;
        tick();
        idle_inputs();
        tick();
        check_eq("d044_npulse", 512'(q_ready.size()), 512'd1);
        if (q_ready.size() == 1) check_eq("d044_port", 512'(q_ready[0]), 512'd0);

        // Bridge ready pulse while idle has no effect.
        i_axi_io_ready = 1; i_axi_io_rdata = rand512() | 512'd1; i_axi_io_resp = 2'd3;
        #1;
        check_eq("d045_m0_ready", 512'(o_m0_ready), 512'd0);
        check_eq("d045_m1_ready", 512'(o_m1_ready), 512'd0);
        check_eq("d045_rdata", o_rdata, 512'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("d045_stay_idle", 512'(o_axi_io_valid), 512'd0);
        tick();

        // Random traffic with occasional aborts and ignored valid drops.
        n_done = 0;
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (done0) pend0 = 0;
            if (done1) pend1 = 0;
            if ($urandom_range(0, 399) == 0) begin
                assert_reset("rnd_rst");
                idle_inputs();
                pend0 = 0; pend1 = 0;
                tick();
                rst_n = 1;
                continue;
            end
            if (!pend0 && $urandom_range(0, 3) == 0) begin
                pend0 = 1;
                i_m0_addr = {$urandom, $urandom}; i_m0_size = 2'($urandom); i_m0_blks = 8'($urandom);
            end
            if (!pend1 && $urandom_range(0, 3) == 0) begin
                pend1 = 1;
                i_m1_op = 1'($urandom); i_m1_addr = {$urandom, $urandom};
                i_m1_size = 2'($urandom); i_m1_blks = 8'($urandom); i_m1_wdata = rand512();
            end
            i_m0_valid = pend0;
            i_m1_valid = pend1;
            if (m_busy && $urandom_range(0, 7) == 0) begin
                if (m_owner) begin i_m1_valid = 0; i_m1_addr = {$urandom, $urandom}; end
                else begin i_m0_valid = 0; i_m0_addr = {$urandom, $urandom}; end
            end
            i_axi_io_ready = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            i_axi_io_rdata = rand512();
            i_axi_io_resp  = 2'($urandom);
            tick();
        end
        check_eq("rnd_progress", 512'(n_done > 100), 512'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_user_arbiter.md
AXI_USER_ARBITER -- requirements
Module: axi_user_arbiter

Interface
REQ-001 SHALL have no parameters; widths fixed: addr 64, data 512, size 2, blks 8, resp 2.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_m0_valid  input  1  instruction-side read request, held until o_m0_ready.
REQ-005 i_m0_addr  input  64  m0 request address.
REQ-006 i_m0_size  input  2  m0 beat size code.
REQ-007 i_m0_blks  input  8  m0 burst length minus one.
REQ-008 o_m0_ready  output  1  one-cycle m0 completion pulse.
REQ-009 i_m1_valid  input  1  data-side request, held until o_m1_ready.
REQ-010 i_m1_op  input  1  m1 direction, 0 read, 1 write.
REQ-011 i_m1_addr  input  64  m1 request address.
REQ-012 i_m1_size  input  2  m1 beat size code.
REQ-013 i_m1_blks  input  8  m1 burst length minus one.
REQ-014 i_m1_wdata  input  512  m1 write data.
REQ-015 o_m1_ready  output  1  one-cycle m1 completion pulse.
REQ-016 o_rdata  output  512  read data shared by both requesters, valid only with their ready.
REQ-017 o_resp  output  2  response shared by both requesters, valid only with their ready.
REQ-018 o_axi_io_valid  output  1  request to the AXI bridge user port.
REQ-019 o_axi_io_op  output  1  bridge direction.
REQ-020 o_axi_io_addr  output  64  bridge address.
REQ-021 o_axi_io_size  output  2  bridge size.
REQ-022 o_axi_io_blks  output  8  bridge burst length minus one.
REQ-023 o_axi_io_wdata  output  512  bridge write data.
REQ-024 i_axi_io_ready  input  1  bridge one-cycle completion pulse.
REQ-025 i_axi_io_rdata  input  512  bridge read data.
REQ-026 i_axi_io_resp  input  2  bridge response.

Function
REQ-027 FSM SHALL have states IDLE, BUSY_M0, BUSY_M1; one transaction outstanding max.
REQ-028 In IDLE, one valid requester: grant it; both valid: grant the port not granted last (last_grant register).
REQ-029 On grant edge, addr/size/blks/op/wdata SHALL be captured into registers; the FSM enters BUSY_x.
REQ-030 m0 grants SHALL drive op=0, wdata=0.
REQ-031 o_axi_io_valid SHALL be 1 exactly in BUSY states; bridge fields come from registers and stay stable throughout.
REQ-032 Latency: requester valid in IDLE at cycle N -> o_axi_io_valid=1 at N+1.
REQ-033 In BUSY_x with i_axi_io_ready=1: same cycle, o_mx_ready=1; o_rdata/o_resp=i_axi_io_rdata/resp (combinational); next edge -> IDLE, last_grant=x.
REQ-034 o_mx_ready SHALL never assert for the non-granted port, nor outside BUSY_x; o_rdata/o_resp are 0 when no ready.
REQ-035 i_axi_io_ready in IDLE SHALL be ignored.
REQ-036 Requester dropping valid mid-transaction SHALL be ignored; the transaction completes and the ready pulse is still issued.
REQ-037 At least one IDLE cycle SHALL separate consecutive bridge transactions.
REQ-038 Continuous requests from both ports SHALL alternate grants (no starvation).

Reset
REQ-039 rst_n=0 SHALL immediately (asynchronously) force: state IDLE, last_grant=m0 (so m1 wins the first tie), all captured registers and outputs 0, including mid-transaction; no ready pulse is generated for an aborted transaction.

Verification
REQ-040 m0 valid addr=0x8000_0000 size=3 blks=0; bridge ready on 5th BUSY cycle with rdata=0xDEAD -> o_axi_io_valid 5 cycles, op=0, o_m0_ready one cycle, o_rdata=0xDEAD.
REQ-041 Both valid first cycle after reset -> m1 granted; after its ready, one IDLE cycle, then m0 granted.
REQ-042 Both held valid for 4 transactions -> grant order m1,m0,m1,m0.
REQ-043 m1 write op=1 wdata=0xA5 pattern, i_m1_addr changed after grant -> bridge addr/wdata stay at captured values until ready.
REQ-044 rst_n low during BUSY_M1 -> o_axi_io_valid=0 same cycle, no o_m1_ready; after release a new m0 request completes normally.
REQ-045 i_axi_io_ready pulsed in IDLE -> o_m0_ready=o_m1_ready=0, state stays IDLE.
